// File: rtl/mio_bridge.sv
// ---------------------------------------------------------------------------
// mio_bridge
//
// Memory/IO bridge sitting directly after the CPU's MEM stage. It decodes the
// CPU byte address into a word-addressed data RAM or a small set of
// memory-mapped peripherals: an LED register, synchronised switches and a
// programmable down-counting timer whose expiry flag drives the CPU interrupt.
// Reads are combinational (zero latency); writes land on the rising edge
// where mem_w is high.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   reset      synchronous, active-high reset
//   mem_w      CPU store strobe
//   addr_in    CPU byte address (bits [1:0] ignored, word accesses only)
//   wdata_in   CPU store data
//   rdata_out  read data back to the CPU, combinational from addr_in
//   MIO_ready  always 1, every access completes in one cycle
//   sw_in      asynchronous board switches
//   led_out    LED register value
//   int_out    timer interrupt request (EXP & IRQ_EN)
// ---------------------------------------------------------------------------
module mio_bridge #(
  parameter int RAM_WORDS = 1024,
  parameter int SW_WIDTH  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mem_w,
  input  logic [31:0]         addr_in,
  input  logic [31:0]         wdata_in,
  output logic [31:0]         rdata_out,
  output logic                MIO_ready,
  input  logic [SW_WIDTH-1:0] sw_in,
  output logic [SW_WIDTH-1:0] led_out,
  output logic                int_out
);

  localparam int AW = $clog2(RAM_WORDS);

  localparam logic [31:0] ADDR_LED    = 32'hF000_0000;
  localparam logic [31:0] ADDR_SW     = 32'hF000_0004;
  localparam logic [31:0] ADDR_COUNT  = 32'hF000_0008;
  localparam logic [31:0] ADDR_RELOAD = 32'hF000_000C;
  localparam logic [31:0] ADDR_CTRL   = 32'hF000_0010;
  localparam logic [31:0] ADDR_STATUS = 32'hF000_0014;

  logic [31:0]         r_ram [RAM_WORDS];
  logic [SW_WIDTH-1:0] r_led;
  logic [SW_WIDTH-1:0] r_swMeta;
  logic [SW_WIDTH-1:0] r_swSync;
  logic [31:0]         r_count;
  logic [31:0]         r_reload;
  logic                r_en;
  logic                r_irqEn;
  logic                r_auto;
  logic                r_exp;

  logic [31:0]         w_wordAddr;
  logic                w_ramSel;
  logic [AW-1:0]       w_ramIdx;
  logic                w_selLed;
  logic                w_selReload;
  logic                w_selCtrl;
  logic                w_selStatus;
  logic                w_expire;
  logic                w_unused;

  // Address decode. The byte offset is dropped; RAM occupies the first 4 KiB
  // and wraps modulo its depth, peripherals are matched on the full word.
  assign w_wordAddr  = {addr_in[31:2], 2'b00};
  assign w_ramSel    = (addr_in[31:12] == 20'h0_0000);
  assign w_ramIdx    = addr_in[AW+1:2];
  assign w_selLed    = (w_wordAddr == ADDR_LED);
  assign w_selReload = (w_wordAddr == ADDR_RELOAD);
  assign w_selCtrl   = (w_wordAddr == ADDR_CTRL);
  assign w_selStatus = (w_wordAddr == ADDR_STATUS);
  assign w_unused    = ^{addr_in[1:0], addr_in[11:2]};

  // The timer expires on an edge where it is enabled and already at zero.
  assign w_expire = r_en && (r_count == 32'd0);

  assign MIO_ready = 1'b1;
  assign led_out   = r_led;
  assign int_out   = r_exp & r_irqEn;

  // Combinational read mux: the CPU gets its data in the same cycle the
  // address is presented, so a store's own cycle still sees the old value.
  always_comb begin
    rdata_out = 32'd0;
    if (w_ramSel) begin
      rdata_out = r_ram[w_ramIdx];
    end else begin
      case (w_wordAddr)
        ADDR_LED:    rdata_out = 32'(r_led);
        ADDR_SW:     rdata_out = 32'(r_swSync);
        ADDR_COUNT:  rdata_out = r_count;
        ADDR_RELOAD: rdata_out = r_reload;
        ADDR_CTRL:   rdata_out = {29'd0, r_auto, r_irqEn, r_en};
        ADDR_STATUS: rdata_out = {31'd0, r_exp};
        default:     rdata_out = 32'd0;
      endcase
    end
  end

  // Data RAM: asynchronous read above, synchronous write here. Contents are
  // deliberately left out of reset so this maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (mem_w && w_ramSel) begin
      r_ram[w_ramIdx] <= wdata_in;
    end
  end

  // Two-flop synchroniser for the asynchronous switches, plus the LED
  // register which only the CPU writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_swMeta <= '0;
      r_swSync <= '0;
      r_led    <= '0;
    end else begin
      r_swMeta <= sw_in;
      r_swSync <= r_swMeta;
      if (mem_w && w_selLed) begin
        r_led <= wdata_in[SW_WIDTH-1:0];
      end
    end
  end

  // Timer. The autonomous countdown/expiry is written first so that the CPU
  // writes below override it: a RELOAD write wins over decrement/reload of
  // COUNT, and a CTRL write wins over the one-shot auto-clear of EN. The W1C
  // clear of EXP is suppressed on an expiry edge so a fresh expiry is never
  // lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count  <= 32'd0;
      r_reload <= 32'd0;
      r_en     <= 1'b0;
      r_irqEn  <= 1'b0;
      r_auto   <= 1'b0;
      r_exp    <= 1'b0;
    end else begin
      if (r_en) begin
        if (r_count != 32'd0) begin
          r_count <= r_count - 32'd1;
        end else begin
          r_exp <= 1'b1;
          if (r_auto) begin
            r_count <= r_reload;
          end else begin
            r_en <= 1'b0;
          end
        end
      end
      if (mem_w && w_selReload) begin
        r_reload <= wdata_in;
        r_count  <= wdata_in;
      end
      if (mem_w && w_selCtrl) begin
        r_en    <= wdata_in[0];
        r_irqEn <= wdata_in[1];
        r_auto  <= wdata_in[2];
      end
      if (mem_w && w_selStatus && wdata_in[0] && !w_expire) begin
        r_exp <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mio_bridge.sv
// ---------------------------------------------------------------------------
// tb_mio_bridge
//
// Self-checking bench for mio_bridge. A behavioural model of the address map
// (RAM as an associative array, peripheral registers as plain variables,
// switch history as a two-entry shift list) predicts every read, LED and
// interrupt value. Directed scenarios follow the worked examples; random
// traffic exercises the RAM, switches and timer priorities.
// ---------------------------------------------------------------------------
module tb_mio_bridge;

  localparam logic [31:0] A_LED    = 32'hF000_0000;
  localparam logic [31:0] A_SW     = 32'hF000_0004;
  localparam logic [31:0] A_COUNT  = 32'hF000_0008;
  localparam logic [31:0] A_RELOAD = 32'hF000_000C;
  localparam logic [31:0] A_CTRL   = 32'hF000_0010;
  localparam logic [31:0] A_STATUS = 32'hF000_0014;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_w;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic [31:0] rdata_out;
  logic        MIO_ready;
  logic [15:0] sw_in;
  logic [15:0] led_out;
  logic        int_out;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] mRam [int];
  logic [15:0] mLed;
  logic [15:0] mSwHist [2];
  logic [31:0] mCount;
  logic [31:0] mReload;
  logic        mEn, mIrqEn, mAuto, mExp;

  mio_bridge #(.RAM_WORDS(1024), .SW_WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_w     (mem_w),
    .addr_in   (addr_in),
    .wdata_in  (wdata_in),
    .rdata_out (rdata_out),
    .MIO_ready (MIO_ready),
    .sw_in     (sw_in),
    .led_out   (led_out),
    .int_out   (int_out)
  );

  // 20-unit clock; stimulus is applied 1 unit after each rising edge
  always #10 clk = ~clk;

  // Expected read value of any address from the model
  function automatic logic [31:0] modelRead(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w < 32'h0000_1000) begin
      if (mRam.exists(int'(w[11:2]))) return mRam[int'(w[11:2])];
      return 32'h0;
    end
    case (w)
      A_LED:    return {16'h0, mLed};
      A_SW:     return {16'h0, mSwHist[1]};
      A_COUNT:  return mCount;
      A_RELOAD: return mReload;
      A_CTRL:   return {29'd0, mAuto, mIrqEn, mEn};
      A_STATUS: return {31'd0, mExp};
      default:  return 32'h0;
    endcase
  endfunction

  // True when the coming edge is a timer expiry
  function automatic logic modelExpiresNow();
    return mEn && (mCount == 32'd0);
  endfunction

  // Advance the model by one rising edge
  task automatic modelEdge(input logic we, input logic [31:0] a, input logic [31:0] d);
    logic        expiry;
    logic [31:0] w;
    expiry = modelExpiresNow();
    w = {a[31:2], 2'b00};
    mSwHist[1] = mSwHist[0];
    mSwHist[0] = sw_in;
    if (mEn) begin
      if (expiry) begin
        mExp = 1'b1;
        if (mAuto) mCount = mReload;
        else mEn = 1'b0;
      end else begin
        mCount = mCount - 1;
      end
    end
    if (we) begin
      if (w < 32'h0000_1000) mRam[int'(w[11:2])] = d;
      else if (w == A_LED) mLed = d[15:0];
      else if (w == A_RELOAD) begin mReload = d; mCount = d; end
      else if (w == A_CTRL) begin mEn = d[0]; mIrqEn = d[1]; mAuto = d[2]; end
      else if (w == A_STATUS && d[0] && !expiry) mExp = 1'b0;
    end
  endtask

  // Drive one bus cycle; preRead is the read data seen before the edge
  task automatic applyStimulus(input logic we, input logic [31:0] a, input logic [31:0] d,
                               output logic [31:0] preRead);
    mem_w    = we;
    addr_in  = a;
    wdata_in = d;
    #1;
    preRead = rdata_out;
    @(posedge clk);
    modelEdge(we, a, d);
    #1;
    mem_w    = 1'b0;
    addr_in  = 32'h0;
    wdata_in = $urandom;
  endtask

  // Combinational read within the current cycle (costs 1 time unit)
  task automatic readBus(input logic [31:0] a, output logic [31:0] v);
    mem_w   = 1'b0;
    addr_in = a;
    #1;
    v = rdata_out;
  endtask

  task automatic doReset();
    reset = 1'b1;
    mem_w = 1'b0;
    @(posedge clk);
    mLed = '0; mSwHist[0] = '0; mSwHist[1] = '0;
    mCount = '0; mReload = '0; mEn = 0; mIrqEn = 0; mAuto = 0; mExp = 0;
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [31:0] addrs [6];
    addrs = '{A_LED, A_SW, A_COUNT, A_RELOAD, A_CTRL, A_STATUS};
    sw_in = 16'h0000;
    doReset();
    foreach (addrs[i]) begin
      readBus(addrs[i], v);
      checks++;
      if (v !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_read[%0d]: got %h expected %h", i, v, 32'h0);
      end
    end
    checks++;
    if (MIO_ready !== 1'b1 || led_out !== 16'h0 || int_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got ready=%b led=%h int=%b expected 1/0000/0",
               MIO_ready, led_out, int_out);
    end
  endtask

  task automatic test_ram();
    logic [31:0] v, pre, expv, a, d;
    logic        we;
    applyStimulus(1'b1, 32'h0000_0010, 32'h1111_1111, pre);
    applyStimulus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, pre);
    checks++;
    if (pre !== 32'h1111_1111) begin
      errors++;
      $display("[TB] FAIL ram_same_cycle: got %h expected %h", pre, 32'h1111_1111);
    end
    readBus(32'h0000_0010, v);
    checks++;
    if (v !== 32'hDEAD_BEEF) begin
      errors++;
      $display("[TB] FAIL ram_readback: got %h expected %h", v, 32'hDEAD_BEEF);
    end
    // Random traffic: the pre-edge read must show the prior contents
    for (int i = 0; i < 40; i++) begin
      a  = $urandom_range(0, 32'h0FFF);
      d  = $urandom;
      we = ($urandom_range(0, 3) != 0);
      expv = modelRead(a);
      applyStimulus(we, a, d, pre);
      if (mRam.exists(int'(a[11:2])) && !(we && expv === 32'hx)) begin
        checks++;
        if (pre !== expv && mRam.exists(int'(a[11:2])) && !(we && !modelHadWord(a, expv))) begin
          errors++;
          $display("[TB] FAIL ram_rand_pre[%0d]: got %h expected %h", i, pre, expv);
        end
      end
    end
    // Read back every written word, using a different byte offset
    foreach (mRam[k]) begin
      a = {20'h0, 10'(k), 2'(k)};
      readBus(a, v);
      checks++;
      if (v !== mRam[k]) begin
        errors++;
        $display("[TB] FAIL ram_rand_read[%0d]: got %h expected %h", k, v, mRam[k]);
      end
      applyStimulus(1'b0, 32'h0, 32'h0, pre);
    end
    // Store to an unmapped address changes nothing visible
    applyStimulus(1'b1, 32'hF000_0100, 32'hFFFF_FFFF, pre);
    readBus(32'hF000_0100, v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("[TB] FAIL unmapped_read: got %h expected %h", v, 32'h0);
    end
    readBus(32'h0000_0010, v);
    checks++;
    if (v !== 32'hDEAD_BEEF || led_out !== mLed) begin
      errors++;
      $display("[TB] FAIL unmapped_write: got ram=%h led=%h expected %h/%h",
               v, led_out, 32'hDEAD_BEEF, mLed);
    end
  endtask

  // Whether the RAM model held a defined word for a before the last edge
  function automatic logic modelHadWord(input logic [31:0] a, input logic [31:0] expv);
    return (expv !== 32'hx) && mRam.exists(int'(a[11:2]));
  endfunction

  task automatic test_led_sw();
    logic [31:0] v, pre;
    applyStimulus(1'b1, A_LED, 32'h1234_A5A5, pre);
    readBus(A_LED, v);
    checks++;
    if (led_out !== 16'hA5A5 || v !== 32'h0000_A5A5) begin
      errors++;
      $display("[TB] FAIL led_write: got led=%h read=%h expected a5a5/0000a5a5", led_out, v);
    end
    sw_in = 16'h00FF;
    applyStimulus(1'b0, 32'h0, 32'h0, pre);
    readBus(A_SW, v);
    checks++;
    if (v === 32'h0000_00FF) begin
      errors++;
      $display("[TB] FAIL sw_early: got %h expected old value %h", v, modelRead(A_SW));
    end
    applyStimulus(1'b0, 32'h0, 32'h0, pre);
    readBus(A_SW, v);
    checks++;
    if (v !== 32'h0000_00FF) begin
      errors++;
      $display("[TB] FAIL sw_sync: got %h expected %h", v, 32'h0000_00FF);
    end
    for (int i = 0; i < 20; i++) begin
      sw_in = 16'($urandom);
      applyStimulus(1'b0, 32'h0, 32'h0, pre);
      readBus(A_SW, v);
      checks++;
      if (v !== modelRead(A_SW)) begin
        errors++;
        $display("[TB] FAIL sw_rand[%0d]: got %h expected %h", i, v, modelRead(A_SW));
      end
    end
    // SW is read-only
    applyStimulus(1'b1, A_SW, 32'hFFFF_FFFF, pre);
    readBus(A_SW, v);
    checks++;
    if (v !== modelRead(A_SW)) begin
      errors++;
      $display("[TB] FAIL sw_ro: got %h expected %h", v, modelRead(A_SW));
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] v, pre;
    logic [31:0] expCount [4];
    logic        expInt [4];
    expCount = '{32'd2, 32'd1, 32'd0, 32'd0};
    expInt   = '{1'b0, 1'b0, 1'b0, 1'b1};
    applyStimulus(1'b1, A_RELOAD, 32'd3, pre);
    applyStimulus(1'b1, A_CTRL, 32'h3, pre);
    for (int e = 0; e < 4; e++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, pre);
      readBus(A_COUNT, v);
      checks++;
      if (v !== expCount[e] || int_out !== expInt[e]) begin
        errors++;
        $display("[TB] FAIL oneshot_edge%0d: got count=%0d int=%b expected %0d/%b",
                 e + 1, v, int_out, expCount[e], expInt[e]);
      end
    end
    applyStimulus(1'b0, 32'h0, 32'h0, pre);
    readBus(A_CTRL, v);
    checks++;
    if (v !== 32'h2) begin
      errors++;
      $display("[TB] FAIL oneshot_ctrl: got %h expected %h", v, 32'h2);
    end
    readBus(A_COUNT, v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("[TB] FAIL oneshot_hold: got %h expected %h", v, 32'h0);
    end
    applyStimulus(1'b1, A_STATUS, 32'h0, pre);
    checks++;
    if (int_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL status_w0: got int=%b expected 1", int_out);
    end
    applyStimulus(1'b1, A_STATUS, 32'h1, pre);
    checks++;
    if (int_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL status_w1c: got int=%b expected 0", int_out);
    end
  endtask

  task automatic test_auto();
    logic [31:0] v, pre;
    int          expiries;
    logic        w1c, expiring;
    applyStimulus(1'b1, A_RELOAD, 32'd1, pre);
    applyStimulus(1'b1, A_CTRL, 32'h7, pre);
    expiries = 0;
    // With RELOAD=1 the timer expires on every second edge
    for (int e = 1; e <= 12; e++) begin
      expiring = modelExpiresNow();
      if (expiring) expiries++;
      w1c = ($urandom_range(0, 1) == 1);
      applyStimulus(w1c, A_STATUS, 32'h1, pre);
      readBus(A_STATUS, v);
      checks++;
      if (v !== modelRead(A_STATUS) || int_out !== mExp || expiring !== (e % 2 == 0)) begin
        errors++;
        $display("[TB] FAIL auto_edge%0d: got status=%h int=%b expected %h/%b",
                 e, v, int_out, modelRead(A_STATUS), mExp);
      end
    end
    // W1C exactly on an expiry edge must leave EXP set
    if (!modelExpiresNow()) applyStimulus(1'b1, A_STATUS, 32'h1, pre);
    applyStimulus(1'b1, A_STATUS, 32'h1, pre);
    readBus(A_STATUS, v);
    checks++;
    if (v !== 32'h1) begin
      errors++;
      $display("[TB] FAIL auto_w1c_collide: got %h expected %h", v, 32'h1);
    end
    // RELOAD=0 with AUTO expires on every edge, so W1C never wins
    applyStimulus(1'b1, A_RELOAD, 32'd0, pre);
    for (int e = 0; e < 6; e++) begin
      applyStimulus(1'b1, A_STATUS, 32'h1, pre);
      readBus(A_STATUS, v);
      checks++;
      if (v !== 32'h1) begin
        errors++;
        $display("[TB] FAIL auto_reload0[%0d]: got %h expected %h", e, v, 32'h1);
      end
    end
  endtask

  task automatic test_priority();
    logic [31:0] v, pre, d, a;
    logic        we;
    applyStimulus(1'b1, A_CTRL, 32'h0, pre);
    applyStimulus(1'b1, A_STATUS, 32'h1, pre);
    // CTRL write beats the one-shot auto-clear of EN
    applyStimulus(1'b1, A_RELOAD, 32'd0, pre);
    applyStimulus(1'b1, A_CTRL, 32'h1, pre);
    applyStimulus(1'b1, A_CTRL, 32'h1, pre);
    readBus(A_CTRL, v);
    checks++;
    if (v !== 32'h1) begin
      errors++;
      $display("[TB] FAIL ctrl_beats_clear: got %h expected %h", v, 32'h1);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, pre);
    readBus(A_CTRL, v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("[TB] FAIL oneshot_clear: got %h expected %h", v, 32'h0);
    end
    // RELOAD write beats the decrement
    applyStimulus(1'b1, A_RELOAD, 32'd5, pre);
    applyStimulus(1'b1, A_CTRL, 32'h1, pre);
    applyStimulus(1'b1, A_RELOAD, 32'd9, pre);
    readBus(A_COUNT, v);
    checks++;
    if (v !== 32'd9) begin
      errors++;
      $display("[TB] FAIL reload_beats_dec: got %0d expected %0d", v, 9);
    end
    // Random timer register traffic against the model
    for (int i = 0; i < 80; i++) begin
      we = 1'b1;
      case ($urandom_range(0, 4))
        0: begin a = A_RELOAD; d = $urandom_range(0, 4); end
        1: begin a = A_CTRL;   d = $urandom_range(0, 7); end
        2: begin a = A_STATUS; d = $urandom_range(0, 1); end
        3: begin a = A_COUNT;  d = $urandom; end
        default: begin we = 1'b0; a = 32'h0; d = 32'h0; end
      endcase
      applyStimulus(we, a, d, pre);
      readBus(A_COUNT, v);
      checks++;
      if (v !== mCount) begin
        errors++;
        $display("[TB] FAIL rand_count[%0d]: got %h expected %h", i, v, mCount);
      end
      readBus(A_CTRL, v);
      checks++;
      if (v !== modelRead(A_CTRL) || int_out !== (mExp & mIrqEn)) begin
        errors++;
        $display("[TB] FAIL rand_ctrl_int[%0d]: got ctrl=%h int=%b expected %h/%b",
                 i, v, int_out, modelRead(A_CTRL), mExp & mIrqEn);
      end
      readBus(A_STATUS, v);
      checks++;
      if (v !== modelRead(A_STATUS)) begin
        errors++;
        $display("[TB] FAIL rand_status[%0d]: got %h expected %h", i, v, modelRead(A_STATUS));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v, pre;
    logic [31:0] addrs [6];
    addrs = '{A_LED, A_SW, A_COUNT, A_RELOAD, A_CTRL, A_STATUS};
    applyStimulus(1'b1, A_CTRL, 32'h0, pre);
    applyStimulus(1'b1, A_LED, 32'h0000_5A5A, pre);
    applyStimulus(1'b1, A_RELOAD, 32'd5, pre);
    applyStimulus(1'b1, A_CTRL, 32'h3, pre);
    readBus(A_COUNT, v);
    checks++;
    if (v !== 32'd5) begin
      errors++;
      $display("[TB] FAIL midreset_setup: got %0d expected %0d", v, 5);
    end
    sw_in = 16'hFFFF;
    doReset();
    foreach (addrs[i]) begin
      readBus(addrs[i], v);
      checks++;
      if (v !== 32'h0) begin
        errors++;
        $display("[TB] FAIL midreset_read[%0d]: got %h expected %h", i, v, 32'h0);
      end
    end
    for (int e = 0; e < 3; e++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, pre);
      readBus(A_COUNT, v);
      checks++;
      if (v !== 32'h0 || led_out !== 16'h0 || int_out !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midreset_hold[%0d]: got count=%h led=%h int=%b expected 0/0/0",
                 e, v, led_out, int_out);
      end
    end
  endtask

  // Sequence the scenarios and report
  initial begin
    reset    = 1'b1;
    mem_w    = 1'b0;
    addr_in  = 32'h0;
    wdata_in = 32'h0;
    sw_in    = 16'h0;
    test_reset();
    test_ram();
    test_led_sw();
    test_oneshot();
    test_auto();
    test_priority();
    test_reset_mid();
    checks++;
    if (MIO_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_end: got %b expected 1", MIO_ready);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
